// File: rtl/f32_to_i32_seq.sv
// Multi-cycle float32 -> int32 converter (round toward zero) with valid/ready on both sides.
// An iterative shifter moves the mantissa at most SHIFT_STEP bit positions per cycle.
module f32_to_i32_seq #(
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        flag_ovf,
    output logic        flag_nan,
    output logic        flag_inexact
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    logic [1:0]  state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [4:0]  rem_q, rem_d;
    logic        left_q, left_d;
    logic        sign_q, sign_d;
    logic        nan_q, nan_d;
    logic        sat_q, sat_d;
    logic        inexact_q, inexact_d;
    logic [31:0] out_data_q, out_data_d;
    logic        ovf_out_q, ovf_out_d;
    logic        nan_out_q, nan_out_d;
    logic        inx_out_q, inx_out_d;

    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_frac;
    logic [31:0] dec_mag;
    logic [4:0]  dec_rem;
    logic        dec_left, dec_nan, dec_sat, dec_inexact;

    logic [4:0]  step;
    logic [31:0] lost_mask;

    assign in_sign = in_data[31];
    assign in_exp  = in_data[30:23];
    assign in_frac = in_data[22:0];

    // Operand decode at accept time; shift counts use only the low 5 exponent bits
    // (150 mod 32 = 22), which is exact over the in-range exponents 127..157.
    always_comb begin
        dec_mag     = {8'd0, 1'b1, in_frac};
        dec_rem     = 5'd0;
        dec_left    = 1'b0;
        dec_nan     = 1'b0;
        dec_sat     = 1'b0;
        dec_inexact = 1'b0;
        if (in_exp == 8'd255) begin
            dec_mag = 32'd0;
            if (in_frac != 23'd0) begin
                dec_nan = 1'b1;
            end else begin
                dec_sat = 1'b1;
            end
        end else if (in_exp >= 8'd158) begin
            if (in_data == 32'hCF00_0000) begin
                dec_mag = 32'h8000_0000;
            end else begin
                dec_mag = 32'd0;
                dec_sat = 1'b1;
            end
        end else if (in_exp == 8'd0) begin
            dec_mag     = 32'd0;
            dec_inexact = (in_frac != 23'd0);
        end else if (in_exp < 8'd127) begin
            dec_mag     = 32'd0;
            dec_inexact = 1'b1;
        end else if (in_exp <= 8'd149) begin
            dec_rem = 5'd22 - in_exp[4:0];
        end else begin
            dec_rem  = in_exp[4:0] - 5'd22;
            dec_left = 1'b1;
        end
    end

    assign step      = (rem_q < STEP) ? rem_q : STEP;
    assign lost_mask = (32'd1 << step) - 32'd1;

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        rem_d      = rem_q;
        left_d     = left_q;
        sign_d     = sign_q;
        nan_d      = nan_q;
        sat_d      = sat_q;
        inexact_d  = inexact_q;
        out_data_d = out_data_q;
        ovf_out_d  = ovf_out_q;
        nan_out_d  = nan_out_q;
        inx_out_d  = inx_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_d     = dec_mag;
                    rem_d     = dec_rem;
                    left_d    = dec_left;
                    sign_d    = in_sign;
                    nan_d     = dec_nan;
                    sat_d     = dec_sat;
                    inexact_d = dec_inexact;
                    state_d   = (dec_rem != 5'd0) ? SHIFT : FIN;
                end
            end
            SHIFT: begin
                if (left_q) begin
                    mag_d = mag_q << step;
                end else begin
                    mag_d     = mag_q >> step;
                    inexact_d = inexact_q | (|(mag_q & lost_mask));
                end
                rem_d = rem_q - step;
                if (rem_d == 5'd0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (nan_q) begin
                    out_data_d = 32'h7FFF_FFFF;
                end else if (sat_q) begin
                    out_data_d = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                end else begin
                    out_data_d = sign_q ? (32'd0 - mag_q) : mag_q;
                end
                ovf_out_d = sat_q;
                nan_out_d = nan_q;
                inx_out_d = inexact_q;
                state_d   = DONE;
            end
            default: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mag_q      <= 32'd0;
            rem_q      <= 5'd0;
            left_q     <= 1'b0;
            sign_q     <= 1'b0;
            nan_q      <= 1'b0;
            sat_q      <= 1'b0;
            inexact_q  <= 1'b0;
            out_data_q <= 32'd0;
            ovf_out_q  <= 1'b0;
            nan_out_q  <= 1'b0;
            inx_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            rem_q      <= rem_d;
            left_q     <= left_d;
            sign_q     <= sign_d;
            nan_q      <= nan_d;
            sat_q      <= sat_d;
            inexact_q  <= inexact_d;
            out_data_q <= out_data_d;
            ovf_out_q  <= ovf_out_d;
            nan_out_q  <= nan_out_d;
            inx_out_q  <= inx_out_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_data     = out_data_q;
    assign flag_ovf     = ovf_out_q;
    assign flag_nan     = nan_out_q;
    assign flag_inexact = inx_out_q;

endmodule

// File: tb/tb_f32_to_i32_seq.sv
// Directed bench for f32_to_i32_seq: vector table plus backpressure, reset and SHIFT_STEP=1 cases.
module tb_f32_to_i32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic        flag_ovf, flag_nan, flag_inexact;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] in_data1, out_data1;
    logic        flag_ovf1, flag_nan1, flag_inexact1;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    f32_to_i32_seq #(.SHIFT_STEP(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flag_ovf(flag_ovf), .flag_nan(flag_nan), .flag_inexact(flag_inexact)
    );

    f32_to_i32_seq #(.SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .flag_ovf(flag_ovf1), .flag_nan(flag_nan1), .flag_inexact(flag_inexact1)
    );

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic [2:0]  flags;  // {ovf, nan, inexact}
        int          lat;
    } vec_t;

    vec_t vecs[16];

    logic [31:0] got_data;
    logic [2:0]  got_flags;
    int          got_lat;
    logic        busy_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Accept one operand with out_ready=1, measure latency in cycles after the accept edge.
    task automatic run(input logic [31:0] d);
        @(negedge clk);
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_data    = 32'hDEAD_BEEF;
        got_lat    = 0;
        busy_ready = 1'b0;
        got_data   = 32'hX;
        got_flags  = 3'bX;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (in_ready) busy_ready = 1'b1;
            if (out_valid) begin
                got_lat   = c;
                got_data  = out_data;
                got_flags = {flag_ovf, flag_nan, flag_inexact};
                break;
            end
        end
        if (got_lat == 0) begin
            tests++;
            failed++;
            $display("FAIL timeout: out_valid never rose for operand %h", d);
        end
        @(posedge clk);
    endtask

    initial begin
        vecs[0]  = '{32'h3F80_0000, 32'h0000_0001, 3'b000, 5};  // 1.0
        vecs[1]  = '{32'hC020_0000, 32'hFFFF_FFFE, 3'b001, 5};  // -2.5
        vecs[2]  = '{32'h3F00_0000, 32'h0000_0000, 3'b001, 2};  // 0.5
        vecs[3]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 3'b100, 2};  // 2^31
        vecs[4]  = '{32'hCF00_0000, 32'h8000_0000, 3'b000, 2};  // -2^31
        vecs[5]  = '{32'hFF80_0000, 32'h8000_0000, 3'b100, 2};  // -inf
        vecs[6]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 3};  // largest < 2^31
        vecs[7]  = '{32'h7FC0_0000, 32'h7FFF_FFFF, 3'b010, 2};  // NaN
        vecs[8]  = '{32'h4120_0000, 32'h0000_000A, 3'b000, 5};  // 10.0
        vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 3'b000, 2};  // +0
        vecs[10] = '{32'h8000_0001, 32'h0000_0000, 3'b001, 2};  // -denormal
        vecs[11] = '{32'h4B00_0000, 32'h0080_0000, 3'b000, 2};  // 2^23, no shift
        vecs[12] = '{32'h4B80_0001, 32'h0100_0002, 3'b000, 3};  // left by 1
        vecs[13] = '{32'hC2F6_0000, 32'hFFFF_FF85, 3'b000, 5};  // -123.0
        vecs[14] = '{32'h3FFF_FFFF, 32'h0000_0001, 3'b001, 5};  // 1.99999988
        vecs[15] = '{32'hFFC0_0000, 32'h7FFF_FFFF, 3'b010, 2};  // negative NaN

        rst = 1'b1;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = 32'd0; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_data", out_data, 32'd0);
        check("reset_flags", {29'd0, flag_ovf, flag_nan, flag_inexact}, 32'd0);

        foreach (vecs[i]) begin
            run(vecs[i].din);
            check($sformatf("data_%h", vecs[i].din), got_data, vecs[i].dout);
            check($sformatf("flags_%h", vecs[i].din), {29'd0, got_flags}, {29'd0, vecs[i].flags});
            check($sformatf("latency_%h", vecs[i].din), 32'(got_lat), 32'(vecs[i].lat));
            check($sformatf("busy_in_ready_%h", vecs[i].din), {31'd0, busy_ready}, 32'd0);
        end

        // Backpressure: result must hold for 10 cycles while a new operand is offered.
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hC020_0000; out_ready = 1'b0;
        @(posedge clk);
        #1 in_data = 32'h4120_0000;
        got_lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got_lat = c;
                break;
            end
        end
        check("bp_latency", 32'(got_lat), 32'd5);
        for (int c = 0; c < 10; c++) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data", out_data, 32'hFFFF_FFFE);
            check("bp_flags", {29'd0, flag_ovf, flag_nan, flag_inexact}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        got_lat = 0;
        got_data = 32'hX;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got_lat  = c;
                got_data = out_data;
                break;
            end
        end
        check("bp_next_data", got_data, 32'h0000_000A);
        check("bp_next_latency", 32'(got_lat), 32'd5);
        @(posedge clk);

        // Reset in the middle of SHIFT discards the conversion.
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h3F80_0000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_flags", {29'd0, flag_ovf, flag_nan, flag_inexact}, 32'd0);
        run(32'h4120_0000);
        check("post_reset_data", got_data, 32'h0000_000A);
        check("post_reset_latency", 32'(got_lat), 32'd5);

        // SHIFT_STEP=1 instance: 1.0 needs 23 single-bit shifts.
        @(negedge clk);
        in_valid1 = 1'b1; in_data1 = 32'h3F80_0000;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        got_lat = 0;
        got_data = 32'hX;
        got_flags = 3'bX;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (out_valid1) begin
                got_lat   = c;
                got_data  = out_data1;
                got_flags = {flag_ovf1, flag_nan1, flag_inexact1};
                break;
            end
        end
        check("step1_latency", 32'(got_lat), 32'd25);
        check("step1_data", got_data, 32'h0000_0001);
        check("step1_flags", {29'd0, got_flags}, 32'd0);
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
